reset_sequencer: RTL



---
 rtl/reset_sequencer_if.sv | 36 +++
 rtl/reset_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// Reset fan-out bundle between the sequencer (master) and the domains it resets (slave).
// RSTSEQ_CAUSE_EN adds the reset-cause and request-count observation signals.
interface reset_sequencer_if #(
    parameter int NUM_OUTS = 3
);
    logic                sw_req;
    logic [NUM_OUTS-1:0] rst_out;
    logic                ready;
    logic                busy;
`ifdef RSTSEQ_CAUSE_EN
    logic [1:0]          cause;
    logic [7:0]          req_count;
`endif

    modport master (
`ifdef RSTSEQ_CAUSE_EN
        output cause,
        output req_count,
`endif
        input  sw_req,
        output rst_out,
        output ready,
        output busy
    );

    modport slave (
`ifdef RSTSEQ_CAUSE_EN
        input  cause,
        input  req_count,
`endif
        output sw_req,
        input  rst_out,
        input  ready,
        input  busy
    );
endinterface

// File: rtl/reset_sequencer.sv
// Power-on / push-button reset sequencer: holds all domain resets, then releases them bit 0 first.
// Optional feature macro: RSTSEQ_CAUSE_EN (adds cause[1:0] and req_count[7:0]).
module reset_sequencer #(
    parameter int NUM_OUTS    = 3,
    parameter int POR_CYCLES  = 16,
    parameter int STAGE_GAP   = 4,
    parameter int REQ_FILTER  = 8,
    parameter int HOLD_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    reset_sequencer_if.master  bus
);

    localparam int MAX_A = (POR_CYCLES > STAGE_GAP) ? POR_CYCLES : STAGE_GAP;
    localparam int MAX_B = (HOLD_CYCLES > REQ_FILTER) ? HOLD_CYCLES : REQ_FILTER;
    localparam int MAX_V = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_V + 1);

    localparam logic [CW-1:0]       POR_LAST  = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0]       GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0]       FILT_LAST = CW'(REQ_FILTER - 1);
    localparam logic [CW-1:0]       HOLD_V    = CW'(HOLD_CYCLES);
    localparam logic [NUM_OUTS-1:0] ALL_ONES  = {NUM_OUTS{1'b1}};

    typedef enum logic [1:0] {
        S_POR     = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    // Initialisers give a working power-on reset even if rst never asserts.
    state_t              r_state   = S_POR;
    logic [CW-1:0]       r_cnt     = '0;
    logic [CW-1:0]       r_filt    = '0;
    logic [NUM_OUTS-1:0] r_rst_out = ALL_ONES;
    logic                r_ready   = 1'b0;
    logic                r_busy    = 1'b1;

    state_t              w_state_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [CW-1:0]       w_filt_nxt;
    logic [NUM_OUTS-1:0] w_rst_nxt;
    logic                w_req_q;
    logic                w_release;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_filt_nxt  = r_filt;
        w_rst_nxt   = r_rst_out;
        w_req_q     = 1'b0;
        w_release   = 1'b0;

        case (r_state)
            S_POR: begin
                w_filt_nxt = '0;
                if (r_cnt == POR_LAST) begin
                    w_release = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            S_RELEASE, S_RUN: begin
                if (bus.sw_req) begin
                    if (r_filt == FILT_LAST) begin
                        w_req_q = 1'b1;
                    end else begin
                        w_filt_nxt = r_filt + CW'(1);
                    end
                end else begin
                    w_filt_nxt = '0;
                end

                if (r_state == S_RELEASE && !w_req_q) begin
                    if (r_cnt == GAP_LAST) begin
                        w_release = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end

            S_HOLD: begin
                w_filt_nxt = '0;
                if (r_cnt == HOLD_V && !bus.sw_req) begin
                    w_release = 1'b1;
                end else if (r_cnt != HOLD_V) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            default: begin
                w_state_nxt = S_POR;
            end
        endcase

        // A qualified request wins over a release that falls on the same edge.
        if (w_req_q) begin
            w_state_nxt = S_HOLD;
            w_rst_nxt   = ALL_ONES;
            w_cnt_nxt   = '0;
            w_filt_nxt  = '0;
        end else if (w_release) begin
            // Bits release in order, so clearing the lowest set bit frees the next domain.
            w_rst_nxt   = r_rst_out & (r_rst_out - NUM_OUTS'(1));
            w_cnt_nxt   = '0;
            w_state_nxt = (w_rst_nxt == '0) ? S_RUN : S_RELEASE;
        end
    end

`ifdef RSTSEQ_CAUSE_EN
    logic [1:0] r_cause     = 2'b01;
    logic [7:0] r_req_count = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_POR;
            r_cnt     <= '0;
            r_filt    <= '0;
            r_rst_out <= ALL_ONES;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
`ifdef RSTSEQ_CAUSE_EN
            r_cause     <= 2'b01;
            r_req_count <= 8'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_filt    <= w_filt_nxt;
            r_rst_out <= w_rst_nxt;
            r_ready   <= (w_rst_nxt == '0);
            r_busy    <= (w_state_nxt != S_RUN);
`ifdef RSTSEQ_CAUSE_EN
            if (w_req_q) begin
                r_cause <= 2'b10;
                if (r_req_count != 8'hFF) begin
                    r_req_count <= r_req_count + 8'd1;
                end
            end
`endif
        end
    end

    assign bus.rst_out = r_rst_out;
    assign bus.ready   = r_ready;
    assign bus.busy    = r_busy;
`ifdef RSTSEQ_CAUSE_EN
    assign bus.cause     = r_cause;
    assign bus.req_count = r_req_count;
`endif

endmodule
